// File: rtl/pattern_tx_if.sv
// Control and serial-output bundle for the pattern transmitter.
// The master side is the controlling logic; the slave side is pattern_tx.
interface pattern_tx_if #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
);
  logic             Start;
  logic             Abort;
  logic [WIDTH-1:0] Pat;
  logic [REP_W-1:0] Rep;
  logic             Sout;
  logic             Busy;
  logic             Done;

  modport master (
    output Start, Abort, Pat, Rep,
    input  Sout, Busy, Done
  );

  modport slave (
    input  Start, Abort, Pat, Rep,
    output Sout, Busy, Done
  );
endinterface

// File: rtl/pattern_tx.sv
// Serial bit-pattern transmitter: latches a pattern and repeat count on
// Start, shifts the pattern out MSB-first for Rep+1 back-to-back frames,
// then pulses Done for one cycle. Outputs decode from registers only.
module pattern_tx #(
  parameter int WIDTH = 4,
  parameter int REP_W = 4
) (
  input  logic         CP,
  input  logic         nCR,
  pattern_tx_if.slave  bus
);

  localparam int CNT_W = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SEND = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shift_q, shift_d;
  logic [WIDTH-1:0] pat_q, pat_d;
  logic [CNT_W-1:0] bit_cnt_q, bit_cnt_d;
  logic [REP_W-1:0] rep_q, rep_d;

  // State and datapath registers; reset clears everything asynchronously.
  always_ff @(posedge CP or negedge nCR) begin
    if (!nCR) begin
      state_q   <= IDLE;
      shift_q   <= '0;
      pat_q     <= '0;
      bit_cnt_q <= '0;
      rep_q     <= '0;
    end else begin
      state_q   <= state_d;
      shift_q   <= shift_d;
      pat_q     <= pat_d;
      bit_cnt_q <= bit_cnt_d;
      rep_q     <= rep_d;
    end
  end

  // Next-state logic: load on Start, shift/reload per frame, Abort overrides.
  always_comb begin
    state_d   = state_q;
    shift_d   = shift_q;
    pat_d     = pat_q;
    bit_cnt_d = bit_cnt_q;
    rep_d     = rep_q;

    case (state_q)
      IDLE: begin
        if (bus.Start) begin
          pat_d     = bus.Pat;
          shift_d   = bus.Pat;
          rep_d     = bus.Rep;
          bit_cnt_d = LAST_BIT;
          state_d   = SEND;
        end
      end
      SEND: begin
        if (bit_cnt_q != '0) begin
          shift_d   = {shift_q[WIDTH-2:0], 1'b0};
          bit_cnt_d = bit_cnt_q - CNT_W'(1);
        end else if (rep_q != '0) begin
          // Next frame starts on the very next cycle: no gap bit.
          shift_d   = pat_q;
          bit_cnt_d = LAST_BIT;
          rep_d     = rep_q - REP_W'(1);
        end else begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    // Abort wins over everything, including a simultaneous Start in IDLE;
    // the register loads above are harmless because state stays IDLE.
    if (bus.Abort) begin
      state_d = IDLE;
    end
  end

  assign bus.Sout = (state_q == SEND) && shift_q[WIDTH-1];
  assign bus.Busy = (state_q == SEND);
  assign bus.Done = (state_q == DONE);

endmodule

// File: tb/tb_pattern_tx.sv
// Directed bench for pattern_tx: expected {Sout,Busy,Done} per cycle are
// queued when stimulus is applied and compared cycle by cycle.
module tb_pattern_tx;

  localparam int WIDTH = 4;
  localparam int REP_W = 4;

  logic CP  = 1'b0;
  logic nCR = 1'b0;

  pattern_tx_if #(.WIDTH(WIDTH), .REP_W(REP_W)) bus ();

  pattern_tx #(.WIDTH(WIDTH), .REP_W(REP_W)) dut (
    .CP  (CP),
    .nCR (nCR),
    .bus (bus)
  );

  always #5 CP = ~CP;

  int         checks   = 0;
  int         failures = 0;
  logic [2:0] exp_q[$];

  // Overlapping 0101 Mealy detector fed from observed Sout.
  bit          det_en   = 1'b0;
  logic [3:0]  det_hist = '0;
  int          det_cyc  = 0;
  logic [31:0] det_mask = '0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic push_idle(input int n);
    for (int i = 0; i < n; i++) exp_q.push_back(3'b000);
  endtask

  task automatic push_frames(input logic [WIDTH-1:0] pat, input int rep);
    for (int f = 0; f <= rep; f++)
      for (int b = WIDTH - 1; b >= 0; b--)
        exp_q.push_back({pat[b], 2'b10});
    exp_q.push_back(3'b001);
  endtask

  // Compare n cycles at the falling edge; return just after the next rising edge.
  task automatic run_check(input int n, input string tag);
    logic [2:0] e;
    for (int i = 0; i < n; i++) begin
      @(negedge CP);
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $error("FAIL %s: scoreboard empty, observed=%b", tag, {bus.Sout, bus.Busy, bus.Done});
      end else begin
        e = exp_q.pop_front();
        check_eq(tag, {29'd0, bus.Sout, bus.Busy, bus.Done}, {29'd0, e});
      end
      if (det_en) begin
        det_hist = {det_hist[2:0], bus.Sout};
        det_cyc++;
        if (det_hist == 4'b0101) det_mask[det_cyc] = 1'b1;
      end
      @(posedge CP);
      #1;
    end
  endtask

  // Present a transfer request for exactly one edge (edge 0).
  task automatic start_tx(input logic [WIDTH-1:0] pat, input logic [REP_W-1:0] rep);
    bus.Pat   = pat;
    bus.Rep   = rep;
    bus.Start = 1'b1;
    @(posedge CP);
    #1;
    bus.Start = 1'b0;
  endtask

  initial begin
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    bus.Pat   = '0;
    bus.Rep   = '0;

    // Reset held for 3 cycles, then 10 idle cycles.
    push_idle(3);
    run_check(3, "reset");
    nCR = 1'b1;
    push_idle(10);
    run_check(10, "idle");

    // Single frame 0101, Rep=0: data cycles 1-4, Done in 5, idle after.
    start_tx(4'b0101, 4'd0);
    push_frames(4'b0101, 0);
    push_idle(2);
    run_check(7, "single");

    // Two frames of 0101 into the overlapping detector: hits at 4, 6, 8.
    det_en = 1'b1; det_hist = '0; det_cyc = 0; det_mask = '0;
    start_tx(4'b0101, 4'd1);
    push_frames(4'b0101, 1);
    push_idle(1);
    run_check(10, "repeat");
    det_en = 1'b0;
    check_eq("det_hits", det_mask, 32'h0000_0150);

    // Start held high, Pat/Rep changed mid-transfer: exactly 3x 1100.
    bus.Pat   = 4'b1100;
    bus.Rep   = 4'd2;
    bus.Start = 1'b1;
    @(posedge CP);
    #1;
    push_frames(4'b1100, 2);
    run_check(3, "busy_start");
    bus.Pat = 4'b0011;
    bus.Rep = 4'd0;
    run_check(10, "busy_start");
    bus.Start = 1'b0;
    push_idle(3);
    run_check(3, "busy_after");

    // Abort sampled at edge 6 of a 4-frame 1111 transfer.
    start_tx(4'b1111, 4'd3);
    for (int i = 0; i < 6; i++) exp_q.push_back(3'b110);
    run_check(5, "abort_pre");
    bus.Abort = 1'b1;
    run_check(1, "abort_pre");
    bus.Abort = 1'b0;
    push_idle(5);
    run_check(5, "abort_post");

    // Abort together with Start in IDLE: no transfer.
    bus.Pat   = 4'b1010;
    bus.Rep   = 4'd0;
    bus.Start = 1'b1;
    bus.Abort = 1'b1;
    @(posedge CP);
    #1;
    bus.Start = 1'b0;
    bus.Abort = 1'b0;
    push_idle(6);
    run_check(6, "abort_start");

    // Asynchronous reset pulsed in the middle of cycle 3.
    start_tx(4'b1111, 4'd3);
    exp_q.push_back(3'b110);
    exp_q.push_back(3'b110);
    run_check(2, "arst_pre");
    #2 nCR = 1'b0;
    #1 check_eq("arst_now", {29'd0, bus.Sout, bus.Busy, bus.Done}, 32'd0);
    #2 nCR = 1'b1;
    @(posedge CP);
    #1;
    push_idle(4);
    run_check(4, "arst_post");

    // Maximum repeat: 16 frames = 64 data cycles, Done in cycle 65.
    start_tx(4'b1011, 4'hF);
    push_frames(4'b1011, 15);
    push_idle(2);
    run_check(67, "max_rep");

    check_eq("sb_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/pattern_tx.md
Name: pattern_tx

Overview:
Serial bit-pattern transmitter; the generating end of the serial bit-sequence detectors in the state_machine library. Latches a WIDTH-bit pattern and a repeat count on Start. Shifts the pattern out MSB-first on Sout, one bit per CP cycle, back-to-back for Rep+1 frames. Busy/Done handshake toward the controlling logic. Used to drive detector Sin inputs in-system and in benches.

Parameters:
WIDTH, 4, pattern length in bits (>=2)
REP_W, 4, width of repeat-count input

Ports:
CP  input  1  clock, rising edge
nCR  input  1  asynchronous active-low reset
Start  input  1  request to transmit; sampled only in IDLE
Abort  input  1  synchronous cancel; valid in any state
Pat  input  WIDTH  pattern; Pat[WIDTH-1] sent first
Rep  input  REP_W  extra frame count; Rep+1 frames sent
Sout  output  1  serial data
Busy  output  1  high while bits are being sent
Done  output  1  one-cycle completion pulse

Behaviour:
- Reset (nCR=0, asynchronous): state=IDLE, Sout=0, Busy=0, Done=0, shift reg=0, bit counter=0, repeat counter=0, latched pattern=0.
- States: IDLE, SEND, DONE. Registered state; outputs decode from registers only, with no combinational path from any input to any output.
- IDLE: Sout=0, Busy=0, Done=0. On an edge with Start=1 and Abort=0: latch Pat into the pattern register and the shift register, latch Rep into the repeat counter, set bit counter=WIDTH-1, go to SEND.
- SEND: Busy=1, Sout=shift reg MSB. At each edge:
  - bit counter != 0: shift left by 1, decrement bit counter.
  - bit counter == 0 and repeat counter != 0: reload shift reg from the latched pattern, set bit counter=WIDTH-1, decrement repeat counter. No gap bit between frames.
  - bit counter == 0 and repeat counter == 0: go to DONE.
- DONE: Done=1, Busy=0, Sout=0 for exactly one cycle; then IDLE.
- Latency: Start sampled at edge 0. The first bit appears on Sout in cycle 1. The last bit appears in cycle (Rep+1)*WIDTH. Done is high in cycle (Rep+1)*WIDTH+1. The earliest next Start is accepted at the edge ending the cycle after Done.
- Start is ignored in SEND and DONE, with no queuing. Pat and Rep may change freely after the accepting edge without affecting the transfer.
- Abort=1 at any edge forces IDLE at that edge, clears Sout/Busy, and produces no Done pulse. Abort and Start at the same edge in IDLE: Abort wins and the block stays IDLE.
- Rep=0 sends one frame. Rep=2^REP_W-1 sends 2^REP_W frames; counters must not wrap early.
- Reset asserted mid-transfer aborts immediately (asynchronously) with no Done pulse. After release the block waits in IDLE for a new Start.

Test Plan:
- Reset then idle: nCR low 3 cycles, release, Start=0 for 10 cycles -> Sout=0, Busy=0, Done=0 throughout.
- Single frame: WIDTH=4, Pat=4'b0101, Rep=0, Start pulse at edge 0 -> Sout=0,1,0,1 in cycles 1-4; Busy=1 in cycles 1-4; Done=1 in cycle 5 only; back in IDLE at cycle 6.
- Repeat with overlapping detection: Pat=4'b0101, Rep=1, Sout driven into an overlapping 0101 Mealy detector model -> stream 01010101 in cycles 1-8; detector Out pulses in cycles 4, 6 and 8 (3 pulses); Done in cycle 9.
- Start and input changes while busy: Pat=4'b1100, Rep=2, Start held high and Pat changed to 4'b0011 during the transfer -> exactly 1100 1100 1100 sent; one Done pulse in cycle 13; no second transfer begins until Start is seen in IDLE.
- Abort mid-frame: Pat=4'b1111, Rep=3, Abort=1 sampled at edge 6 -> Sout=1 in cycles 1-6, then Sout=0 and Busy=0 from cycle 7; no Done pulse. Separately, Abort=1 together with Start in IDLE -> no transfer.
- Async reset mid-transfer, plus max repeat: nCR pulsed low mid-cycle during cycle 3 -> Sout/Busy drop before the next edge with no Done. Then Rep=4'hF with WIDTH=4 -> 64 data cycles, Done in cycle 65.
